// File: rtl/lsu_pkg.sv
// ============================================================================
// Module   : lsu_pkg
// Brief    : Shared types and constants for the load/store unit controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        SZ_B  = 3'b000,
        SZ_H  = 3'b001,
        SZ_W  = 3'b010,
        SZ_BU = 3'b100,
        SZ_HU = 3'b101
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// ============================================================================
// Module   : lsu_align
// Brief    : Byte-lane mask, store replication, load extraction, error check.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_align
    import lsu_pkg::*;
(
    input  logic              we,
    input  logic [2:0]        funct3,
    input  logic [1:0]        offset,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [3:0]        mask,
    output logic [DATA_W-1:0] wdata_rep,
    output logic [DATA_W-1:0] rdata_ext,
    output logic              err
);

    logic [DATA_W-1:0] shifted;

    always_comb begin
        shifted   = mem_rdata >> {offset, 3'b000};
        mask      = 4'b0000;
        wdata_rep = '0;
        rdata_ext = '0;
        err       = 1'b0;
        case (funct3)
            SZ_B: begin
                mask      = 4'b0001 << offset;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
            end
            SZ_H: begin
                mask      = 4'b0011 << offset;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
                err       = offset[0];
            end
            SZ_W: begin
                mask      = 4'b1111;
                wdata_rep = wdata;
                rdata_ext = mem_rdata;
                err       = |offset;
            end
            // Unsigned sizes have no store form.
            SZ_BU: begin
                mask      = 4'b0001 << offset;
                rdata_ext = {24'd0, shifted[7:0]};
                err       = we;
            end
            SZ_HU: begin
                mask      = 4'b0011 << offset;
                rdata_ext = {16'd0, shifted[15:0]};
                err       = we | offset[0];
            end
            default: err = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/lsu_ctrl.sv
// ============================================================================
// Module   : lsu_ctrl
// Brief    : Single-outstanding load/store controller (IDLE/ACCESS/RESP).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_ctrl
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_rd_en,
    output logic        mem_wr_en,
    output logic [3:0]  mem_mask,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              is_idle;
    logic              al_we;
    logic [2:0]        al_funct3;
    logic [1:0]        al_offset;
    logic [DATA_W-1:0] al_wdata;
    logic [3:0]        al_mask;
    logic [DATA_W-1:0] al_wdata_rep;
    logic [DATA_W-1:0] al_rdata_ext;
    logic              al_err;

    // In IDLE the aligner sees the incoming request so its error flag can
    // steer the accept; afterwards it works from the captured request.
    assign is_idle   = (state_q == ST_IDLE);
    assign al_we     = is_idle ? req_we         : we_q;
    assign al_funct3 = is_idle ? req_funct3     : funct3_q;
    assign al_offset = is_idle ? req_addr[1:0]  : addr_q[1:0];
    assign al_wdata  = is_idle ? req_wdata      : wdata_q;

    lsu_align u_align (
        .we        (al_we),
        .funct3    (al_funct3),
        .offset    (al_offset),
        .wdata     (al_wdata),
        .mem_rdata (mem_rdata),
        .mask      (al_mask),
        .wdata_rep (al_wdata_rep),
        .rdata_ext (al_rdata_ext),
        .err       (al_err)
    );

    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = '0;
        rsp_err   = 1'b0;
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        mem_mask  = 4'b0000;
        mem_addr  = '0;
        mem_wdata = '0;
        state_d   = state_q;
        we_d      = we_q;
        funct3_d  = funct3_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;

        if (!rst) begin
            case (state_q)
                ST_IDLE:   req_ready = 1'b1;
                ST_ACCESS: begin
                    mem_rd_en = ~we_q;
                    mem_wr_en = we_q;
                    mem_mask  = al_mask;
                    mem_addr  = {2'b00, addr_q[31:2]};
                    mem_wdata = we_q ? al_wdata_rep : '0;
                end
                ST_RESP: begin
                    rsp_valid = 1'b1;
                    rsp_rdata = rdata_q;
                    rsp_err   = err_q;
                end
                default: ;
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    rdata_d  = '0;
                    err_d    = al_err;
                    state_d  = al_err ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                rdata_d = we_q ? '0 : al_rdata_ext;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
// ============================================================================
// Module   : tb_lsu_ctrl
// Brief    : Scoreboard bench for lsu_ctrl against a byte-level memory model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [3:0]  mem_mask;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    lsu_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_rd_en  (mem_rd_en),
        .mem_wr_en  (mem_wr_en),
        .mem_mask   (mem_mask),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        err;
        logic [31:0] waddr;
        logic [3:0]  mask;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_mem [16];
    logic [31:0] dut_mem [16];
    int          n_checks = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          hold = 0;

    // Memory seen by the DUT; reloaded from the reference image during reset.
    assign mem_rdata = dut_mem[mem_addr[3:0]];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            for (int i = 0; i < 16; i++) dut_mem[i] <= ref_mem[i];
        end else if (mem_wr_en) begin
            for (int b = 0; b < 4; b++)
                if (mem_mask[b]) dut_mem[mem_addr[3:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: access size in bytes, alignment as "offset divisible by size".
    task automatic predict(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, output exp_t e);
        int     nb, off, idx;
        bit     sgn, legal;
        longint v, lim;
        nb = 1; sgn = 0; legal = 1;
        case (f3)
            3'd0: begin nb = 1; sgn = 1; end
            3'd1: begin nb = 2; sgn = 1; end
            3'd2: begin nb = 4; end
            3'd4: begin nb = 1; legal = !we; end
            3'd5: begin nb = 2; legal = !we; end
            default: legal = 0;
        endcase
        off     = int'(addr % 4);
        idx     = int'((addr / 4) % 16);
        e.we    = we;
        e.waddr = addr >> 2;
        e.err   = !legal || (off % nb != 0);
        e.mask  = '0;
        e.wdata = '0;
        e.rdata = '0;
        if (!e.err) begin
            e.mask = 4'(((1 << nb) - 1) << off);
            if (we) begin
                if (nb == 1)      e.wdata = {24'd0, wd[7:0]} * 32'h0101_0101;
                else if (nb == 2) e.wdata = {16'd0, wd[15:0]} * 32'h0001_0001;
                else              e.wdata = wd;
                for (int i = 0; i < nb; i++)
                    ref_mem[idx][8*(off+i) +: 8] = wd[8*i +: 8];
            end else begin
                lim = longint'(1) << (8 * nb);
                v   = (longint'(ref_mem[idx]) >> (8 * off)) % lim;
                if (sgn && v >= lim / 2) v = v - lim;
                e.rdata = v[31:0];
            end
        end
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd);
        exp_t e;
        bit   done;
        predict(we, f3, addr, wd, e);
        exp_q.push_back(e);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        done = 0;
        for (int n = 0; n < 100 && !done; n++) begin
            if (req_ready) begin
                @(posedge clk); #1;
                done = 1;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) chk("accept_timeout", 32'd0, 32'd1);
        req_valid = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            if (hold > 0) begin
                rsp_ready = 1'b0;
                hold--;
            end else begin
                rsp_ready = ($urandom % 4) != 0;
            end
        end
    end

    // Monitor: strobe, latency, stability and response checks against the queue head.
    exp_t        m;
    logic        prev_valid = 1'b0;
    logic [31:0] prev_rdata = '0;
    logic        prev_err = 1'b0;
    int          strobes = 0;
    int          acc_cyc = 0;
    bit          acc_pending = 0;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            prev_valid  = 1'b0;
            strobes     = 0;
            acc_pending = 0;
        end else begin
            if (req_valid && req_ready) begin
                acc_cyc     = cyc;
                acc_pending = 1;
            end
            if (mem_rd_en || mem_wr_en) begin
                strobes++;
                chk("strobe_excl", {31'd0, mem_rd_en & mem_wr_en}, 32'd0);
                if (exp_q.size() == 0) begin
                    chk("strobe_unexpected", 32'd1, 32'd0);
                end else begin
                    m = exp_q[0];
                    chk("strobe_on_err", {31'd0, m.err}, 32'd0);
                    chk("mem_wr_en", {31'd0, mem_wr_en}, {31'd0, m.we});
                    chk("mem_addr", mem_addr, m.waddr);
                    chk("mem_mask", {28'd0, mem_mask}, {28'd0, m.mask});
                    if (m.we) chk("mem_wdata", mem_wdata, m.wdata);
                end
            end else begin
                chk("mask_idle", {28'd0, mem_mask}, 32'd0);
            end
            if (rsp_valid) begin
                chk("req_ready_in_resp", {31'd0, req_ready}, 32'd0);
                if (!prev_valid) begin
                    if (acc_pending && exp_q.size() > 0)
                        chk("latency", cyc - acc_cyc, exp_q[0].err ? 32'd1 : 32'd2);
                    acc_pending = 0;
                end else begin
                    chk("rdata_stable", rsp_rdata, prev_rdata);
                    chk("err_stable", {31'd0, rsp_err}, {31'd0, prev_err});
                end
                if (rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("rsp_unexpected", 32'd1, 32'd0);
                    end else begin
                        m = exp_q.pop_front();
                        chk("rsp_rdata", rsp_rdata, m.rdata);
                        chk("rsp_err", {31'd0, rsp_err}, {31'd0, m.err});
                        chk("strobe_count", strobes, m.err ? 32'd0 : 32'd1);
                    end
                    strobes = 0;
                end
            end
            prev_valid = rsp_valid && !rsp_ready;
            prev_rdata = rsp_rdata;
            prev_err   = rsp_err;
        end
    end

    initial begin
        bit drained;
        for (int i = 0; i < 16; i++) ref_mem[i] = $urandom;
        ref_mem[0] = 32'h80FF_1234;

        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_mem_rd_en", {31'd0, mem_rd_en}, 32'd0);
        chk("rst_mem_wr_en", {31'd0, mem_wr_en}, 32'd0);
        chk("rst_mem_mask", {28'd0, mem_mask}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", {31'd0, req_ready}, 32'd1);

        do_req(1'b1, 3'b000, 32'h06, 32'h0000_00A5);   // SB
        do_req(1'b0, 3'b001, 32'h02, 32'h0);           // LH
        do_req(1'b0, 3'b101, 32'h02, 32'h0);           // LHU
        do_req(1'b0, 3'b000, 32'h01, 32'h0);           // LB
        do_req(1'b0, 3'b010, 32'h05, 32'h0);           // misaligned LW
        do_req(1'b1, 3'b100, 32'h00, 32'h1234_5678);   // SBU is illegal
        hold = 9;
        do_req(1'b0, 3'b010, 32'h04, 32'h0);           // long backpressure

        // Reset landing in the ACCESS cycle of a load.
        do_req(1'b0, 3'b010, 32'h08, 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_rd_en", {31'd0, mem_rd_en}, 32'd0);
        chk("midrst_wr_en", {31'd0, mem_wr_en}, 32'd0);
        chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("midrst_req_ready", {31'd0, req_ready}, 32'd1);
        repeat (2) begin
            @(negedge clk);
            chk("midrst_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end

        for (int k = 0; k < 200; k++) begin
            do_req(1'($urandom), 3'($urandom_range(0, 7)), 32'($urandom_range(0, 63)), $urandom);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        drained = 0;
        for (int n = 0; n < 200 && !drained; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0) drained = 1;
        end
        if (!drained) chk("drain_timeout", 32'd0, 32'd1);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 16; i++) chk($sformatf("mem_word%0d", i), dut_mem[i], ref_mem[i]);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-002 The block SHALL have these request ports: req_valid in 1; req_ready out 1; req_we in 1 (1 = store); req_funct3 in 3; req_addr in 32 (byte address); req_wdata in 32.
REQ-003 The block SHALL have these response ports: rsp_valid out 1; rsp_ready in 1; rsp_rdata out 32 (extended load data, 0 for stores); rsp_err out 1 (misaligned or illegal funct3).
REQ-004 The block SHALL have these memory ports: mem_rd_en out 1; mem_wr_en out 1; mem_mask out 4; mem_addr out 32 (word index = req_addr>>2); mem_wdata out 32; mem_rdata in 32 (combinational read).

Function
REQ-005 The block SHALL implement a three-state FSM: IDLE, ACCESS, RESP.
REQ-006 req_ready SHALL be 1 only in IDLE, and a request SHALL be accepted when req_valid && req_ready, registering we, funct3, addr and wdata.
REQ-007 IDLE SHALL go to ACCESS on accept of a legal request, and directly to RESP with rsp_err=1 on accept of an illegal one.
REQ-008 ACCESS SHALL last exactly one cycle, asserting mem_rd_en (load) or mem_wr_en (store) with mem_addr and mem_mask, and SHALL capture mem_rdata at its end.
REQ-009 RESP SHALL hold rsp_valid=1 with stable rsp_rdata and rsp_err until rsp_ready=1, then return to IDLE.
REQ-010 The block SHALL NOT accept a new request in the cycle rsp handshake completes, so back-to-back throughput is one access per 3 cycles.
REQ-011 Latency SHALL be rsp_valid asserted 2 cycles after accept for legal requests and 1 cycle after accept for errored requests.
REQ-012 Legal funct3 values SHALL be 000 B, 001 H, 010 W, 100 BU and 101 HU, with BU and HU legal for loads only.
REQ-013 A request SHALL be misaligned if it is H/HU with addr[0]=1, or W with addr[1:0]≠00.
REQ-014 An errored request SHALL assert no memory strobe, and SHALL return rsp_rdata=0 with rsp_err=1.
REQ-015 mem_mask SHALL be B: 0001<<addr[1:0]; H: 0011<<addr[1:0]; W: 1111; and 0000 outside ACCESS.
REQ-016 mem_wdata SHALL be the store value replicated: B = {4{wdata[7:0]}}; H = {2{wdata[15:0]}}; W = wdata.
REQ-017 Load data SHALL be mem_rdata shifted right by 8*addr[1:0], then sign-extended (B, H) or zero-extended (BU, HU); W SHALL pass unchanged.
REQ-018 mem_rd_en and mem_wr_en SHALL be mutually exclusive and asserted only in ACCESS.
REQ-019 Any req_valid held while not ready SHALL be ignored, and the requester SHALL hold the request stable until accepted.

Reset
REQ-020 rst sampled high SHALL force the FSM to IDLE, including from ACCESS or RESP, and SHALL discard any in-flight access.
REQ-021 During and after reset the outputs SHALL be req_ready=1 (0 while rst high), rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_rd_en=0, mem_wr_en=0, mem_mask=0, mem_addr=0, mem_wdata=0.
REQ-022 The first request SHALL be acceptable in the first cycle after rst deasserts.

Structure
REQ-023 Package lsu_pkg SHALL hold the funct3 size enum (B, H, W, BU, HU), the FSM state enum and the 32-bit data-width constant.
REQ-024 A combinational sub-module lsu_align SHALL compute mask, store replication, load extraction and error detection, and lsu_ctrl SHALL hold only the FSM and registers.
REQ-025 The total RTL SHALL be no more than 400 lines.

Verification
REQ-026 Store: SB addr=0x06, wdata=0x000000A5 -> one ACCESS cycle with mem_wr_en=1, mem_addr=1, mask=0100, mem_wdata=0xA5A5A5A5; then rsp_valid, rsp_err=0.
REQ-027 Load sign/zero extension: mem_rdata=0x80FF1234; LH addr=0x02 -> rsp_rdata=0xFFFF80FF; LHU addr=0x02 -> 0x000080FF; LB addr=0x01 -> 0x00000012.
REQ-028 Misaligned: LW addr=0x05 -> no strobe, rsp_valid one cycle after accept, rsp_err=1, rsp_rdata=0; SBU (req_we=1, funct3=100) -> rsp_err=1.
REQ-029 Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0 throughout; completes on rsp_ready=1.
REQ-030 Reset mid-op: rst in ACCESS cycle -> mem strobes 0 next cycle, no response issued, req_ready=1 the cycle after rst falls.
